// File: rtl/uart_bus_if.sv
// Processor I/O bus between the tramelblaze core and the UART controller.
// Handshake: write_strobe and read_strobe are single-cycle qualifiers for
// port_id/out_port. The peripheral never stalls them, so there is no ready
// signal. in_port is valid combinationally in the same cycle as port_id.
// interrupt is a level held until int_ack.
interface uart_bus_if;
  logic [15:0] port_id;
  logic [15:0] out_port;
  logic        write_strobe;
  logic        read_strobe;
  logic        int_ack;
  logic [15:0] in_port;
  logic        interrupt;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, int_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, int_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/uart_periph_ctl.sv
// Processor-side UART controller.
// Contains port-mapped registers, TX and RX FIFOs, line config and baud
// selection, and a maskable edge-triggered interrupt.
module uart_periph_ctl #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  uart_bus_if.slave   bus,
  output logic [18:0] k,
  output logic        eight,
  output logic        pen,
  output logic        ohel,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ferr,
  input  logic        rx_perr,
  input  logic        rx_ovf,
  output logic        rx_clr,
  output logic        dbg_tx_state,
  output logic        dbg_rx_state
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_t;

  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;

  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [9:0]       rx_mem_q [RX_DEPTH];

  logic       tx_load_q, tx_load_d, rx_clr_q, rx_clr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [3:0] ie_q, ie_d;
  logic [6:0] cfg_q, cfg_d;
  logic       rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d;
  logic       int_q, int_d, cause_q, cause_d;

  logic [15:0] off;
  logic        hit, wr0, wr1, wr2, wr3, rd0;
  logic        tx_empty, tx_full, rx_empty, rx_full, tx_busy;
  logic        tx_pop, tx_push, tx_drop, rx_pop, rx_push_req, rx_push, rx_drop;
  logic        rx_ovf_set;
  logic [9:0]  rx_head;
  logic        unused_ok;

  // Address decode relative to the register block base.
  assign off = bus.port_id - BASE_ADDR;
  assign hit = (off[15:2] == 14'd0);
  assign wr0 = bus.write_strobe & hit & (off[1:0] == 2'd0);
  assign wr1 = bus.write_strobe & hit & (off[1:0] == 2'd1);
  assign wr2 = bus.write_strobe & hit & (off[1:0] == 2'd2);
  assign wr3 = bus.write_strobe & hit & (off[1:0] == 2'd3);
  assign rd0 = bus.read_strobe & hit & (off[1:0] == 2'd0);
  assign unused_ok = &{1'b0, bus.out_port[15:8]};

  assign tx_empty = (tx_cnt_q == TX_CW'(0));
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign rx_empty = (rx_cnt_q == RX_CW'(0));
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign tx_busy  = (tx_state_q != TX_IDLE) | ~tx_rdy;
  assign rx_head  = rx_mem_q[rx_rd_q];

  // A push into a full FIFO is kept only if a pop frees a slot in the same cycle.
  assign tx_push = wr0 & (~tx_full | tx_pop);
  assign tx_drop = wr0 & tx_full & ~tx_pop;
  assign rx_pop  = rd0 & ~rx_empty;
  assign rx_push = rx_push_req & (~rx_full | rx_pop);
  assign rx_drop = rx_push_req & rx_full & ~rx_pop;

  assign tx_load      = tx_load_q;
  assign tx_data      = tx_data_q;
  assign rx_clr       = rx_clr_q;
  assign eight        = cfg_q[4];
  assign pen          = cfg_q[5];
  assign ohel         = cfg_q[6];
  assign bus.interrupt = int_q;
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;

  // TX FSM: hand one byte to the engine per engine busy period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    tx_load_d  = 1'b0;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: if (tx_rdy && !tx_empty) begin
        tx_load_d  = 1'b1;
        tx_data_d  = tx_mem_q[tx_rd_q];
        tx_pop     = 1'b1;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (!tx_rdy) tx_state_d = TX_IDLE;
    endcase
  end

  // RX FSM: capture an engine byte, clear the engine, then wait a cycle so
  // the engine has dropped rx_rdy before the next capture is considered.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_push_req = 1'b0;
    rx_clr_d    = 1'b0;
    rx_ovf_set  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_rdy) begin
        rx_push_req = 1'b1;
        rx_clr_d    = 1'b1;
        rx_ovf_set  = rx_ovf;
        rx_state_d  = RX_HOLD;
      end
      RX_HOLD: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    tx_wr_d  = tx_push ? tx_wr_q + TX_AW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + TX_AW'(1) : tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TX_CW'(1);
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);
    rx_wr_d  = rx_push ? rx_wr_q + RX_AW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + RX_AW'(1) : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RX_CW'(1);
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CW'(1);
  end

  // Software registers, sticky overrun flags (set beats clear) and interrupt latch.
  always_comb begin
    ie_d     = wr2 ? bus.out_port[3:0] : ie_q;
    cfg_d    = wr3 ? bus.out_port[6:0] : cfg_q;
    rx_ovr_d = rx_ovr_q & ~(wr1 & bus.out_port[4]);
    tx_ovr_d = tx_ovr_q & ~(wr1 & bus.out_port[5]);
    if (rx_drop || rx_ovf_set) rx_ovr_d = 1'b1;
    if (tx_drop) tx_ovr_d = 1'b1;
    cause_d = (ie_q[0] & tx_empty & (tx_state_q == TX_IDLE))
            | (ie_q[1] & ~rx_empty)
            | (ie_q[2] & ~rx_empty & (rx_head[9] | rx_head[8]))
            | (ie_q[3] & (rx_ovr_q | tx_ovr_q));
    int_d = int_q & ~bus.int_ack;
    if (cause_d && !cause_q) int_d = 1'b1;
  end

  // Read mux and baud divisor lookup.
  always_comb begin
    bus.in_port = 16'h0000;
    if (hit) begin
      case (off[1:0])
        2'd0: if (!rx_empty) bus.in_port = {6'b0, rx_head};
        2'd1: bus.in_port = {9'b0, tx_busy, tx_ovr_q, rx_ovr_q, rx_full,
                             rx_empty, tx_empty, tx_full};
        2'd2: bus.in_port = {12'b0, ie_q};
        2'd3: bus.in_port = {9'b0, cfg_q};
      endcase
    end
    case (cfg_q[3:0])
      4'd0:    k = 19'd333333;
      4'd1:    k = 19'd83333;
      4'd2:    k = 19'd41667;
      4'd3:    k = 19'd20833;
      4'd5:    k = 19'd5208;
      4'd6:    k = 19'd2604;
      4'd7:    k = 19'd1736;
      4'd8:    k = 19'd868;
      4'd9:    k = 19'd434;
      4'd10:   k = 19'd217;
      4'd11:   k = 19'd109;
      default: k = 19'd10417;
    endcase
  end

  // FIFO storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= bus.out_port[7:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= {rx_perr, rx_ferr, rx_data};
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_cnt_q   <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_clr_q   <= 1'b0;
      ie_q       <= 4'h0;
      cfg_q      <= 7'h14;
      rx_ovr_q   <= 1'b0;
      tx_ovr_q   <= 1'b0;
      int_q      <= 1'b0;
      cause_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      rx_clr_q   <= rx_clr_d;
      ie_q       <= ie_d;
      cfg_q      <= cfg_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovr_q   <= tx_ovr_d;
      int_q      <= int_d;
      cause_q    <= cause_d;
    end
  end
endmodule
